// File: rtl/aes_sbox_sched_pkg.sv
// Shared types for the S-box issue scheduler: requester identity and the
// ownership tag that travels alongside each operand in the S-box pipeline.
package aes_sbox_sched_pkg;

    localparam int unsigned BYTES = 4;

    typedef enum logic {
        OWN_ST = 1'b0,
        OWN_KS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_ST};

endpackage

// File: rtl/sbox_tag_pipe.sv
// Ownership tag shift register running in lockstep with the S-box pipeline;
// tag_out lines up with the S-box result of the same operand.
module sbox_tag_pipe
    import aes_sbox_sched_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage[i] <= TAG_IDLE;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage[i] <= TAG_IDLE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[LATENCY-1];

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/aes_sbox_sched.sv
// Round-robin sharing of one masked S-box pipeline between the state (ST)
// and key-schedule (KS) requesters, with tag-based response routing.
module aes_sbox_sched
    import aes_sbox_sched_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [32*d-1:0] st_data,
    input  logic            ks_valid,
    output logic            ks_ready,
    input  logic [32*d-1:0] ks_data,
    output logic [32*d-1:0] sbox_in,
    output logic            sbox_in_valid,
    input  logic [32*d-1:0] sbox_out,
    output logic            st_rsp_valid,
    output logic [32*d-1:0] st_rsp_data,
    output logic            ks_rsp_valid,
    output logic [32*d-1:0] ks_rsp_data,
    output logic            busy
);

    localparam int unsigned W = 8 * BYTES * d;

    owner_e last_grant;
    logic   grant_st;
    logic   grant_ks;
    logic   acc_st;
    logic   acc_ks;
    tag_t   issue_tag;
    tag_t   tag_out;
    logic   tag_busy;
    logic   ret_st;
    logic   ret_ks;

    // Contested slot goes to whoever did not win last; ties after reset favour KS.
    always_comb begin
        grant_st = st_valid && (!ks_valid || (last_grant == OWN_KS));
        grant_ks = ks_valid && (!st_valid || (last_grant == OWN_ST));
        st_ready = grant_st && !flush;
        ks_ready = grant_ks && !flush;
        acc_st   = st_valid && st_ready;
        acc_ks   = ks_valid && ks_ready;
    end

    // Operand register only loads on accept so idle cycles never toggle shares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbox_in    <= '0;
            issue_tag  <= TAG_IDLE;
            last_grant <= OWN_ST;
        end else begin
            issue_tag.valid <= acc_st || acc_ks;
            if (acc_st || acc_ks) begin
                sbox_in         <= ({W{acc_st}} & st_data) | ({W{acc_ks}} & ks_data);
                issue_tag.owner <= acc_ks ? OWN_KS : OWN_ST;
                last_grant      <= acc_ks ? OWN_KS : OWN_ST;
            end
        end
    end

    assign sbox_in_valid = issue_tag.valid;

    sbox_tag_pipe #(
        .LATENCY(LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .tag_in   (issue_tag),
        .tag_out  (tag_out),
        .any_valid(tag_busy)
    );

    // A result emerging during a flush cycle belongs to dropped work.
    always_comb begin
        ret_st = !flush && tag_out.valid && (tag_out.owner == OWN_ST);
        ret_ks = !flush && tag_out.valid && (tag_out.owner == OWN_KS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rsp_valid <= 1'b0;
            ks_rsp_valid <= 1'b0;
            st_rsp_data  <= '0;
            ks_rsp_data  <= '0;
        end else begin
            st_rsp_valid <= ret_st;
            ks_rsp_valid <= ret_ks;
            if (ret_st) begin
                st_rsp_data <= sbox_out;
            end
            if (ret_ks) begin
                ks_rsp_data <= sbox_out;
            end
        end
    end

    assign busy = sbox_in_valid || tag_busy || st_rsp_valid || ks_rsp_valid;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed and randomized bench for aes_sbox_sched: emulates a masked S-box
// pipeline and checks arbitration, routing, flush and reset behaviour.
module tb_aes_sbox_sched;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        st_valid, st_ready, ks_valid, ks_ready;
    logic [63:0] st_data, ks_data, sbox_in, sbox_out, st_rsp_data, ks_rsp_data;
    logic        sbox_in_valid, st_rsp_valid, ks_rsp_valid, busy;

    int          total = 0;
    int          bad   = 0;
    logic        rand_go = 1'b0;
    logic [7:0]  sbox_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    initial begin
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[x] = b;
        end
    end

    function automatic logic [31:0] sbox_word(input logic [31:0] v);
        return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
    endfunction

    function automatic logic [95:0] mask_word(input logic [31:0] v, input int unsigned dd);
        logic [95:0] r;
        logic        acc;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            acc = v[i];
            for (int unsigned j = 1; j < dd; j++) begin
                r[i*dd+j] = 1'($urandom);
                acc = acc ^ r[i*dd+j];
            end
            r[i*dd] = acc;
        end
        return r;
    endfunction

    function automatic logic [31:0] unmask_word(input logic [95:0] v, input int unsigned dd);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            for (int unsigned j = 0; j < dd; j++) begin
                r[i] = r[i] ^ v[i*dd+j];
            end
        end
        return r;
    endfunction

    // Masked S-box emulator with fresh output shares, 4 stages for the main DUT.
    logic [63:0] pipe_m [4];
    always @(posedge clk) begin
        pipe_m[0] <= 64'(mask_word(sbox_word(unmask_word(96'(sbox_in), 2)), 2));
        for (int i = 1; i < 4; i++) pipe_m[i] <= pipe_m[i-1];
    end
    assign sbox_out = pipe_m[3];

    aes_sbox_sched #(.d(2), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .sbox_in(sbox_in), .sbox_in_valid(sbox_in_valid), .sbox_out(sbox_out),
        .st_rsp_valid(st_rsp_valid), .st_rsp_data(st_rsp_data),
        .ks_rsp_valid(ks_rsp_valid), .ks_rsp_data(ks_rsp_data), .busy(busy)
    );

    // Randomized scoreboard instances: g=0 -> d=3, LATENCY=6; g=1 -> d=2, LATENCY=1.
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int unsigned D = (g == 0) ? 3 : 2;
        localparam int unsigned L = (g == 0) ? 6 : 1;
        localparam int unsigned W = 32 * D;

        logic         r_st_valid, r_st_ready, r_ks_valid, r_ks_ready;
        logic [W-1:0] r_st_data, r_ks_data, r_sbox_in, r_sbox_out, r_st_rsp_data, r_ks_rsp_data;
        logic         r_sbox_in_valid, r_st_rsp_valid, r_ks_rsp_valid, r_busy;
        logic         done = 1'b0;
        logic [W-1:0] pipe [L];

        always @(posedge clk) begin
            pipe[0] <= W'(mask_word(sbox_word(unmask_word(96'(r_sbox_in), D)), D));
            for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
        end
        assign r_sbox_out = pipe[L-1];

        aes_sbox_sched #(.d(D), .LATENCY(L)) u_dut (
            .clk(clk), .rst(rst), .flush(1'b0),
            .st_valid(r_st_valid), .st_ready(r_st_ready), .st_data(r_st_data),
            .ks_valid(r_ks_valid), .ks_ready(r_ks_ready), .ks_data(r_ks_data),
            .sbox_in(r_sbox_in), .sbox_in_valid(r_sbox_in_valid), .sbox_out(r_sbox_out),
            .st_rsp_valid(r_st_rsp_valid), .st_rsp_data(r_st_rsp_data),
            .ks_rsp_valid(r_ks_rsp_valid), .ks_rsp_data(r_ks_rsp_data), .busy(r_busy)
        );

        initial begin
            logic [31:0] st_q [$];
            logic [31:0] ks_q [$];
            logic [31:0] sv, kv, e;
            logic        last_ks, exp_st, exp_ks;
            r_st_valid = 1'b0;
            r_ks_valid = 1'b0;
            r_st_data  = '0;
            r_ks_data  = '0;
            last_ks    = 1'b0;
            wait (rand_go);
            tick();
            for (int n = 0; n < 312; n++) begin
                if (r_st_rsp_valid) begin
                    check("rnd_st_expected", st_q.size() != 0, 1'b1);
                    if (st_q.size() != 0) begin
                        e = st_q.pop_front();
                        check("rnd_st_data", unmask_word(96'(r_st_rsp_data), D), e);
                    end
                end
                if (r_ks_rsp_valid) begin
                    check("rnd_ks_expected", ks_q.size() != 0, 1'b1);
                    if (ks_q.size() != 0) begin
                        e = ks_q.pop_front();
                        check("rnd_ks_data", unmask_word(96'(r_ks_rsp_data), D), e);
                    end
                end
                sv = $urandom;
                kv = $urandom;
                r_st_valid = (n < 300) && ($urandom_range(0, 3) != 0);
                r_ks_valid = (n < 300) && ($urandom_range(0, 3) != 0);
                r_st_data  = W'(mask_word(sv, D));
                r_ks_data  = W'(mask_word(kv, D));
                #1;
                exp_st = r_st_valid && (!r_ks_valid || last_ks);
                exp_ks = r_ks_valid && (!r_st_valid || !last_ks);
                check("rnd_st_ready", r_st_ready, exp_st);
                check("rnd_ks_ready", r_ks_ready, exp_ks);
                if (r_st_valid && r_st_ready) begin
                    st_q.push_back(sbox_word(sv));
                    last_ks = 1'b0;
                end
                if (r_ks_valid && r_ks_ready) begin
                    ks_q.push_back(sbox_word(kv));
                    last_ks = 1'b1;
                end
                tick();
            end
            check("rnd_st_left", st_q.size(), 0);
            check("rnd_ks_left", ks_q.size(), 0);
            check("rnd_busy_end", r_busy, 1'b0);
            done = 1'b1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] a_m, x_m, y_m;
        logic [31:0] sv [3];
        logic [31:0] kv [3];
        logic [31:0] sexp [3];
        logic [31:0] kexp [3];
        logic        exp_s, exp_k, seen;
        int          pulses, w;

        sv   = '{32'h00000000, 32'h01010101, 32'h02020202};
        sexp = '{32'h63636363, 32'h7c7c7c7c, 32'h77777777};
        kv   = '{32'h03030303, 32'h53535353, 32'h10111011};
        kexp = '{32'h7b7b7b7b, 32'hedededed, 32'hca82ca82};

        rst = 1'b1; flush = 1'b0;
        st_valid = 1'b0; ks_valid = 1'b0;
        st_data = '0; ks_data = '0;
        tick();
        tick();
        check("rst_sbox_in_valid", sbox_in_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sbox_in", sbox_in, 64'h0);
        check("rst_st_rsp_valid", st_rsp_valid, 1'b0);
        check("rst_ks_rsp_valid", ks_rsp_valid, 1'b0);
        check("rst_st_rsp_data", st_rsp_data, 64'h0);
        check("rst_ks_rsp_data", ks_rsp_data, 64'h0);
        rst = 1'b0;
        tick();

        // ST-only request, S-box bytes 10 53 01 00 -> ca ed 7c 63
        st_data  = 64'(mask_word(32'h10530100, 2));
        a_m      = st_data;
        st_valid = 1'b1;
        #1;
        check("t1_st_ready", st_ready, 1'b1);
        check("t1_ks_ready", ks_ready, 1'b0);
        tick();
        st_valid = 1'b0;
        st_data  = 64'(mask_word(32'hdeadbeef, 2));
        check("t1_sbox_in", sbox_in, a_m);
        check("t1_sbox_in_valid", sbox_in_valid, 1'b1);
        for (int i = 2; i <= 7; i++) begin
            tick();
            check("t1_st_rsp_valid", st_rsp_valid, i == 6);
            check("t1_busy", busy, i <= 6);
            check("t1_ks_rsp_valid", ks_rsp_valid, 1'b0);
            if (i == 6) check("t1_st_rsp_data", unmask_word(96'(st_rsp_data), 2), 32'hcaed7c63);
        end
        check("t1_st_rsp_hold", unmask_word(96'(st_rsp_data), 2), 32'hcaed7c63);
        check("t1_ks_rsp_data", ks_rsp_data, 64'h0);

        // Both requesters valid for 6 cycles from reset: KS,ST,KS,ST,KS,ST
        do_reset();
        for (int c = 0; c < 6; c++) begin
            st_valid = 1'b1;
            ks_valid = 1'b1;
            st_data  = 64'(mask_word(sv[c/2], 2));
            ks_data  = 64'(mask_word(kv[c/2], 2));
            #1;
            check("t2_ks_ready", ks_ready, (c % 2) == 0);
            check("t2_st_ready", st_ready, (c % 2) == 1);
            tick();
        end
        st_valid = 1'b0;
        ks_valid = 1'b0;
        pulses   = 0;
        for (int j = 6; j <= 13; j++) begin
            exp_k = (j <= 11) && ((j % 2) == 0);
            exp_s = (j <= 11) && ((j % 2) == 1);
            check("t2_ks_rsp_valid", ks_rsp_valid, exp_k);
            check("t2_st_rsp_valid", st_rsp_valid, exp_s);
            if (exp_k) check("t2_ks_rsp_data", unmask_word(96'(ks_rsp_data), 2), kexp[(j-6)/2]);
            if (exp_s) check("t2_st_rsp_data", unmask_word(96'(st_rsp_data), 2), sexp[(j-7)/2]);
            pulses += int'(ks_rsp_valid) + int'(st_rsp_valid);
            tick();
        end
        check("t2_pulses", pulses, 6);

        // Three ST accepts, flush two cycles later
        for (int c = 0; c < 3; c++) begin
            st_valid = 1'b1;
            st_data  = 64'(mask_word(32'h11111111 * (c + 1), 2));
            #1;
            check("t3_st_ready", st_ready, 1'b1);
            tick();
        end
        st_valid = 1'b0;
        tick();
        flush    = 1'b1;
        st_valid = 1'b1;
        ks_valid = 1'b1;
        #1;
        check("t3_flush_st_ready", st_ready, 1'b0);
        check("t3_flush_ks_ready", ks_ready, 1'b0);
        check("t3_busy_before", busy, 1'b1);
        tick();
        flush    = 1'b0;
        st_valid = 1'b0;
        ks_valid = 1'b0;
        check("t3_busy_after", busy, 1'b0);
        check("t3_sbox_in_valid", sbox_in_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | st_rsp_valid | ks_rsp_valid;
            tick();
        end
        check("t3_no_rsp", seen, 1'b0);
        st_valid = 1'b1;
        st_data  = 64'(mask_word(32'h53000000, 2));
        #1;
        check("t3_next_ready", st_ready, 1'b1);
        tick();
        st_valid = 1'b0;
        repeat (5) tick();
        check("t3_next_rsp_valid", st_rsp_valid, 1'b1);
        check("t3_next_rsp_data", unmask_word(96'(st_rsp_data), 2), 32'hed636363);

        // Asynchronous reset with four operands in flight
        tick();
        for (int c = 0; c < 4; c++) begin
            st_valid = 1'b1;
            ks_valid = 1'b1;
            st_data  = 64'(mask_word($urandom, 2));
            ks_data  = 64'(mask_word($urandom, 2));
            tick();
        end
        st_valid = 1'b0;
        ks_valid = 1'b0;
        check("t4_busy_pre", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t4_busy", busy, 1'b0);
        check("t4_sbox_in", sbox_in, 64'h0);
        check("t4_sbox_in_valid", sbox_in_valid, 1'b0);
        check("t4_st_rsp_valid", st_rsp_valid, 1'b0);
        check("t4_ks_rsp_valid", ks_rsp_valid, 1'b0);
        check("t4_st_rsp_data", st_rsp_data, 64'h0);
        check("t4_ks_rsp_data", ks_rsp_data, 64'h0);
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | st_rsp_valid | ks_rsp_valid | busy;
            tick();
        end
        check("t4_no_stale", seen, 1'b0);
        st_valid = 1'b1;
        ks_valid = 1'b1;
        #1;
        check("t4_first_ks_ready", ks_ready, 1'b1);
        check("t4_first_st_ready", st_ready, 1'b0);
        tick();
        check("t4_second_st_ready", st_ready, 1'b1);
        check("t4_second_ks_ready", ks_ready, 1'b0);
        tick();
        st_valid = 1'b0;
        ks_valid = 1'b0;
        repeat (8) tick();

        // Idle gaps: operand register must hold every bit while inputs churn
        st_valid = 1'b1;
        st_data  = 64'(mask_word(32'h0f1e2d3c, 2));
        x_m      = st_data;
        tick();
        st_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            st_data = 64'(mask_word($urandom, 2));
            ks_data = 64'(mask_word($urandom, 2));
            check("t5_sbox_in_hold", sbox_in, x_m);
            check("t5_sbox_in_valid", sbox_in_valid, i == 1);
            check("t5_busy", busy, i <= 6);
            tick();
        end
        ks_valid = 1'b1;
        ks_data  = 64'(mask_word(32'hc3b2a190, 2));
        y_m      = ks_data;
        tick();
        ks_valid = 1'b0;
        ks_data  = 64'(mask_word($urandom, 2));
        check("t5_sbox_in_new", sbox_in, y_m);
        tick();
        check("t5_sbox_in_new_hold", sbox_in, y_m);
        check("t5_sbox_in_valid_low", sbox_in_valid, 1'b0);
        repeat (8) tick();

        rand_go = 1'b1;
        w = 0;
        while (!(g_rnd[0].done && g_rnd[1].done) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        check("rnd_finished", g_rnd[0].done && g_rnd[1].done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
